// File: rtl/trigger_sequencer.sv
// Trigger-condition sequencer: arm, optional edge-count pre-stage,
// then one qualifier on a synchronised input; one-shot trigger pulse.
module trigger_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       sig_in,
  input  logic       cfg_enable,
  input  logic       cfg_positive,
  input  logic [2:0] cfg_type,
  input  logic [3:0] cfg_stage1_count,
  input  logic [2:0] cfg_time_base,
  input  logic [7:0] cfg_count1,
  input  logic [7:0] cfg_count2,
  input  logic       cfg_longer_no_edge,
  output logic       trigger_out,
  output logic       armed,
  output logic       triggered,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STAGE1 = 2'd1,
    S_STAGE2 = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sig_q;
  logic [3:0]         edge_q, edge_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic               pv_q, pv_d;
  logic [13:0]        presc_q, presc_d;
  logic               trig_q, trig_d;

  logic               rise, fall, lead, trail, any_edge, active;
  logic [14:0]        period;
  logic [13:0]        presc_max, presc_eff;
  logic               tick, no_edge, restart, count_en, qual;
  logic [CNT_W-1:0]   width_base, width_inc;
  logic [CNT_W-1:0]   c1, c2, c1p1, limit;

  assign rise     = sig_in & ~sig_q;
  assign fall     = ~sig_in & sig_q;
  assign lead     = cfg_positive ? rise : fall;
  assign trail    = cfg_positive ? fall : rise;
  assign any_edge = sig_in ^ sig_q;
  assign active   = ~(sig_in ^ cfg_positive);

  // Tick period is 4^tb; the restart event re-phases the prescaler
  // so the restart cycle itself is the first cycle of a new period.
  assign period     = 15'd1 << {cfg_time_base, 1'b0};
  assign presc_max  = 14'(period - 15'd1);
  assign no_edge    = (cfg_type == 3'd4);
  assign restart    = no_edge ? any_edge : lead;
  assign presc_eff  = restart ? '0 : presc_q;
  assign tick       = (presc_eff == presc_max);
  assign count_en   = no_edge | ((pv_q | lead) & active);
  assign width_base = restart ? '0 : width_q;
  assign width_inc  = (&width_base) ? width_base
                                    : width_base + CNT_W'(1);

  assign c1    = CNT_W'(cfg_count1);
  assign c2    = CNT_W'(cfg_count2);
  assign c1p1  = c1 + CNT_W'(1);
  assign limit = cfg_longer_no_edge ? CNT_W'({cfg_count1, cfg_count2})
                                    : c1;

  // Qualifier evaluation against the counts registered so far
  always_comb begin
    qual = 1'b0;
    unique case (cfg_type)
      3'd0: qual = lead;
      3'd1: qual = pv_q && (width_q == c1p1);
      3'd2: qual = trail && pv_q && (width_q < c1);
      3'd3: qual = trail && pv_q && (width_q >= c1) && (width_q <= c2);
      3'd4: qual = !any_edge && ((limit == '0) || (width_q == limit));
      default: qual = 1'b0;
    endcase
  end

  // Next-state and counter update; counters rest at zero outside STAGE2
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    width_d = '0;
    pv_d    = 1'b0;
    presc_d = '0;
    trig_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        edge_d = '0;
        if (cfg_enable) begin
          state_d = (cfg_stage1_count == 4'd0) ? S_STAGE2 : S_STAGE1;
        end
      end
      S_STAGE1: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (lead) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == cfg_stage1_count - 4'd1) begin
            state_d = S_STAGE2;
          end
        end
      end
      S_STAGE2: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_eff + 14'd1;
          width_d = (tick && count_en) ? width_inc : width_base;
          pv_d    = lead | (pv_q & ~trail);
          if (qual) begin
            state_d = S_DONE;
            trig_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the delayed input sample
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= S_IDLE;
      sig_q   <= 1'b0;
      edge_q  <= '0;
      width_q <= '0;
      pv_q    <= 1'b0;
      presc_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_in;
      edge_q  <= edge_d;
      width_q <= width_d;
      pv_q    <= pv_d;
      presc_q <= presc_d;
      trig_q  <= trig_d;
    end
  end

  assign trigger_out = trig_q;
  assign armed       = (state_q == S_STAGE1) || (state_q == S_STAGE2);
  assign triggered   = (state_q == S_DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: vector table, directed corner cases
// and random traffic against a timestamp-based reference model.
module tb_trigger_sequencer;

  logic       clk = 1'b0;
  logic       rst_sync, sig_in, cfg_enable, cfg_positive;
  logic       cfg_longer_no_edge;
  logic [2:0] cfg_type, cfg_time_base;
  logic [3:0] cfg_stage1_count;
  logic [7:0] cfg_count1, cfg_count2;
  logic       trigger_out, armed, triggered;
  logic [1:0] state;

  always #5 clk = ~clk;

  trigger_sequencer dut (
    .clk(clk), .rst_sync(rst_sync), .sig_in(sig_in),
    .cfg_enable(cfg_enable), .cfg_positive(cfg_positive),
    .cfg_type(cfg_type), .cfg_stage1_count(cfg_stage1_count),
    .cfg_time_base(cfg_time_base), .cfg_count1(cfg_count1),
    .cfg_count2(cfg_count2), .cfg_longer_no_edge(cfg_longer_no_edge),
    .trigger_out(trigger_out), .armed(armed),
    .triggered(triggered), .state(state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: phase plus timestamps of the last lead / last edge
  int m_state = 0;
  int m_edges = 0;
  int m_lt = 0;
  int m_ref = 0;
  bit m_trig = 0;
  bit m_prev = 0;
  bit m_pv = 0;

  typedef struct {
    bit rst;
    bit en;
    bit sig;
    int exp_state;
    bit exp_trig;
  } vec_t;

  vec_t tbl[0:15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model(input bit r, input bit e, input bit s);
    bit lead, trail, ae, q;
    int ns, p, wp, wn, lim, c1, c2, t;
    t = cyc;
    if (r) begin
      m_state = 0; m_trig = 0; m_prev = 0; m_pv = 0; m_edges = 0;
      return;
    end
    ae    = (s != m_prev);
    lead  = ae && (s == cfg_positive);
    trail = ae && !lead;
    ns = m_state;
    m_trig = 0;
    q = 0;
    p  = 1 << (2 * int'(cfg_time_base));
    c1 = int'(cfg_count1);
    c2 = int'(cfg_count2);
    case (m_state)
      0: if (e) begin
        m_edges = 0;
        if (cfg_stage1_count == 4'd0) begin
          ns = 2; m_pv = 0; m_ref = t + 1;
        end else ns = 1;
      end
      1: if (!e) ns = 0;
      else if (lead) begin
        m_edges++;
        if (m_edges == int'(cfg_stage1_count)) begin
          ns = 2; m_pv = 0; m_ref = t + 1;
        end
      end
      2: if (!e) ns = 0;
      else begin
        wp  = m_pv ? sat((t - m_lt) / p) : 0;
        wn  = sat((t - m_ref) / p);
        lim = cfg_longer_no_edge ? c1 * 256 + c2 : c1;
        case (cfg_type)
          3'd0: q = lead;
          3'd1: q = m_pv && (wp == c1 + 1);
          3'd2: q = trail && m_pv && (wp < c1);
          3'd3: q = trail && m_pv && (wp >= c1) && (wp <= c2);
          3'd4: q = !ae && ((lim == 0) || (wn == lim));
          default: q = 0;
        endcase
        if (q) begin ns = 3; m_trig = 1; end
        if (lead) begin m_pv = 1; m_lt = t; end
        else if (trail) m_pv = 0;
        if (ae) m_ref = t;
      end
      default: if (!e) ns = 0;
    endcase
    m_state = ns;
    m_prev = s;
  endtask

  task automatic step(input bit r, input bit e, input bit s);
    rst_sync = r; cfg_enable = e; sig_in = s;
    @(posedge clk);
    model(r, e, s);
    cyc++;
    #1;
    check("state", int'(state), m_state);
    check("trigger_out", int'(trigger_out), int'(m_trig));
    check("armed", int'(armed), int'(m_state == 1 || m_state == 2));
    check("triggered", int'(triggered), int'(m_state == 3));
  endtask

  task automatic set_cfg(input int ty, input bit pos, input int s1,
                         input int tb, input int a, input int b,
                         input bit lng);
    cfg_type = 3'(ty); cfg_positive = pos;
    cfg_stage1_count = 4'(s1); cfg_time_base = 3'(tb);
    cfg_count1 = 8'(a); cfg_count2 = 8'(b); cfg_longer_no_edge = lng;
  endtask

  initial begin
    int first, seen, lvl, dens;
    bit en_l, r;
    int w[3];
    rst_sync = 1; sig_in = 0; cfg_enable = 0;
    set_cfg(0, 1, 0, 0, 0, 0, 0);

    // table: EDGE, positive, no stage 1
    tbl = '{
      '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 1, 0, 2, 0},
      '{0, 1, 0, 2, 0}, '{0, 1, 0, 2, 0}, '{0, 1, 1, 3, 1},
      '{0, 1, 1, 3, 0}, '{0, 1, 0, 3, 0}, '{0, 1, 1, 3, 0},
      '{0, 0, 1, 0, 0}, '{0, 1, 1, 2, 0}, '{0, 1, 0, 2, 0},
      '{0, 0, 1, 0, 0}, '{0, 1, 1, 2, 0}, '{0, 1, 0, 2, 0},
      '{1, 1, 1, 0, 0}
    };
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].sig);
      check("tbl_state", int'(state), tbl[i].exp_state);
      check("tbl_trig", int'(trigger_out), int'(tbl[i].exp_trig));
    end

    // stage1=3, falling edges lead
    set_cfg(0, 0, 3, 0, 0, 0, 0);
    step(1, 0, 1); step(0, 0, 1); step(0, 1, 1);
    check("s1_enter", int'(state), 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
      check("s1_state", int'(state), (k < 2) ? 1 : (k == 2) ? 2 : 3);
      check("s1_trig", int'(trigger_out), int'(k == 3));
    end

    // PULSE_GT count1=5, tick every 4 cycles
    set_cfg(1, 1, 0, 1, 5, 0, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1); if (trigger_out) seen = 1;
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0); if (trigger_out) seen = 1;
    end
    check("gt_short_none", seen, 0);
    first = -1;
    for (int i = 0; i < 28; i++) begin
      step(0, 1, 1);
      if (trigger_out && first < 0) first = i;
    end
    check("gt_long_index", first, 24);
    check("gt_done", int'(triggered), 1);

    // PULSE_WIN 3..5, pulses 2, 6, 4
    set_cfg(3, 1, 0, 0, 3, 5, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    w = '{2, 6, 4};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < w[k]; i++) step(0, 1, 1);
      step(0, 1, 0);
      check("win_trig", int'(trigger_out), int'(w[k] == 4));
      for (int i = 0; i < 4; i++) step(0, 1, 0);
    end

    // NO_EDGE with 16-bit limit 0x0100
    set_cfg(4, 1, 0, 0, 1, 0, 1);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    lvl = 0; seen = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 99; i++) begin
        step(0, 1, lvl[0]); if (trigger_out) seen = 1;
      end
      lvl = 1 - lvl;
      step(0, 1, lvl[0]); if (trigger_out) seen = 1;
    end
    check("ne_toggle_none", seen, 0);
    first = -1;
    for (int i = 1; i <= 300; i++) begin
      step(0, 1, lvl[0]);
      if (trigger_out && first < 0) first = i;
    end
    check("ne_index", first, 256);

    // NO_EDGE limit 0 fires on first quiet STAGE2 cycle
    set_cfg(4, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    step(0, 1, 0);
    check("ne_zero_fire", int'(trigger_out), 1);

    // PULSE_LT fire, then abort on disable, then reset mid-pulse
    set_cfg(2, 1, 0, 0, 5, 0, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(0, 1, 0);
    check("lt_fire", int'(trigger_out), 1);
    step(0, 0, 0); step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(0, 0, 0);
    check("abort_trig", int'(trigger_out), 0);
    check("abort_state", int'(state), 0);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(1, 1, 1);
    check("rst_outs", int'({state, trigger_out, armed, triggered}), 0);

    // random traffic against the model
    for (int seg = 0; seg < 30; seg++) begin
      set_cfg($urandom_range(0, 5), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 8), $urandom_range(0, 10),
              1'($urandom_range(0, 3) == 0));
      case ($urandom_range(0, 3))
        0: dens = 0;
        1: dens = 2;
        2: dens = 6;
        default: dens = 20;
      endcase
      lvl = 0;
      step(1, 0, 0);
      en_l = 1;
      for (int i = 0; i < 400; i++) begin
        r = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 79) == 0) en_l = !en_l;
        if ($urandom_range(0, dens) == 0) lvl = 1 - lvl;
        step(r, en_l, lvl[0]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
